// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// data_mem_arbiter : round-robin arbiter for processor (P) and DMA (D) access
//                    to a single-port synchronous data memory
// Revision: 1.0
// ============================================================================
module data_mem_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       P_Addr,
  input  logic [DATA_W-1:0] P_WData,
  input  logic              P_Read,
  input  logic              P_Write,
  output logic [DATA_W-1:0] P_RData,
  output logic              P_Waitreq,
  input  logic [15:0]       D_Addr,
  input  logic [DATA_W-1:0] D_WData,
  input  logic              D_Read,
  input  logic              D_Write,
  output logic [DATA_W-1:0] D_RData,
  output logic              D_Waitreq,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  output logic              MemWren,
  input  logic [DATA_W-1:0] MemRData
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RDWAIT = 2'd2,
    S_ACK    = 2'd3
  } state_t;

  localparam logic       C_GNT_P    = 1'b0;
  localparam logic       C_GNT_D    = 1'b1;
  localparam logic [1:0] C_LAT_INIT = 2'(MEM_LAT - 1);

  state_t              state_q, state_d;
  logic                grant_q, grant_d;
  logic                last_grant_q, last_grant_d;
  logic                op_wr_q, op_wr_d;
  logic [1:0]          lat_cnt_q, lat_cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_wren_q, mem_wren_d;

  logic w_p_req;
  logic w_d_req;
  logic w_win;
  logic w_unused_addr;

  assign w_p_req = P_Read | P_Write;
  assign w_d_req = D_Read | D_Write;
  // On a tie the port that did not win last time gets the slot.
  assign w_win   = (w_p_req && w_d_req) ? ~last_grant_q : w_d_req;
  assign w_unused_addr = ^{P_Addr[15:ADDR_W], D_Addr[15:ADDR_W]};

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    op_wr_d      = op_wr_q;
    lat_cnt_d    = lat_cnt_q;
    rdata_d      = rdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wren_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_p_req || w_d_req) begin
          grant_d     = w_win;
          op_wr_d     = (w_win == C_GNT_D) ? D_Write : P_Write;
          mem_wren_d  = (w_win == C_GNT_D) ? D_Write : P_Write;
          mem_addr_d  = (w_win == C_GNT_D) ? D_Addr[ADDR_W-1:0] : P_Addr[ADDR_W-1:0];
          mem_wdata_d = (w_win == C_GNT_D) ? D_WData : P_WData;
          state_d     = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (op_wr_q) begin
          state_d = S_ACK;
        end else begin
          lat_cnt_d = C_LAT_INIT;
          state_d   = S_RDWAIT;
        end
      end
      S_RDWAIT: begin
        if (lat_cnt_q == 2'd0) begin
          rdata_d = MemRData;
          state_d = S_ACK;
        end else begin
          lat_cnt_d = lat_cnt_q - 2'd1;
        end
      end
      S_ACK: begin
        last_grant_d = grant_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      grant_q      <= C_GNT_P;
      last_grant_q <= C_GNT_D;
      op_wr_q      <= 1'b0;
      lat_cnt_q    <= 2'd0;
      rdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wren_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      op_wr_q      <= op_wr_d;
      lat_cnt_q    <= lat_cnt_d;
      rdata_q      <= rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wren_q   <= mem_wren_d;
    end
  end

  assign P_Waitreq = w_p_req & ~((state_q == S_ACK) && (grant_q == C_GNT_P));
  assign D_Waitreq = w_d_req & ~((state_q == S_ACK) && (grant_q == C_GNT_D));
  assign P_RData   = rdata_q;
  assign D_RData   = rdata_q;
  assign MemAddr   = mem_addr_q;
  assign MemWData  = mem_wdata_q;
  assign MemWren   = mem_wren_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_data_mem_arbiter : self-checking bench for data_mem_arbiter
// Revision: 1.0
// ============================================================================
module tb_data_mem_arbiter;

  localparam int AW = 12;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst_b_n;

  logic [15:0]   p_addr, d_addr;
  logic [DW-1:0] p_wdata, d_wdata, p_rdata, d_rdata;
  logic          p_read, p_write, d_read, d_write, p_wait, d_wait;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_wren;

  logic [15:0]   b_addr;
  logic [DW-1:0] b_wdata, b_prdata, b_drdata;
  logic          b_read, b_write, b_pwait, b_dwait;
  logic [AW-1:0] b_mem_addr;
  logic [DW-1:0] b_mem_wdata, b_mem_rdata;
  logic          b_mem_wren;

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .P_Addr(p_addr), .P_WData(p_wdata), .P_Read(p_read), .P_Write(p_write),
    .P_RData(p_rdata), .P_Waitreq(p_wait),
    .D_Addr(d_addr), .D_WData(d_wdata), .D_Read(d_read), .D_Write(d_write),
    .D_RData(d_rdata), .D_Waitreq(d_wait),
    .MemAddr(mem_addr), .MemWData(mem_wdata), .MemWren(mem_wren), .MemRData(mem_rdata)
  );

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_b_n),
    .P_Addr(16'h0), .P_WData(16'h0), .P_Read(1'b0), .P_Write(1'b0),
    .P_RData(b_prdata), .P_Waitreq(b_pwait),
    .D_Addr(b_addr), .D_WData(b_wdata), .D_Read(b_read), .D_Write(b_write),
    .D_RData(b_drdata), .D_Waitreq(b_dwait),
    .MemAddr(b_mem_addr), .MemWData(b_mem_wdata), .MemWren(b_mem_wren), .MemRData(b_mem_rdata)
  );

  // Synchronous memories with one and three cycles of read latency
  logic [DW-1:0] mem_a [0:4095];
  logic [DW-1:0] mem_b [0:4095];
  logic [AW-1:0] pa0, pb0, pb1, pb2;
  always @(posedge clk) begin
    if (mem_wren) mem_a[mem_addr] <= mem_wdata;
    if (b_mem_wren) mem_b[b_mem_addr] <= b_mem_wdata;
    pa0 <= mem_addr;
    pb0 <= b_mem_addr;
    pb1 <= pb0;
    pb2 <= pb1;
  end
  assign mem_rdata   = mem_a[pa0];
  assign b_mem_rdata = mem_b[pb2];

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ref_mem   [0:4095];
  bit            ref_valid [0:4095];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int inst, input bit port, input bit rd, input bit wr,
                       input logic [15:0] a, input logic [15:0] wd);
    if (inst == 1) begin
      b_read = rd; b_write = wr; b_addr = a; b_wdata = wd;
    end else if (port == 1'b0) begin
      p_read = rd; p_write = wr; p_addr = a; p_wdata = wd;
    end else begin
      d_read = rd; d_write = wr; d_addr = a; d_wdata = wd;
    end
  endtask

  // Runs one transfer; lat is edges after the first sampling edge, -1 on timeout
  task automatic do_xfer(input int inst, input bit port, input bit rd, input bit wr,
                         input logic [15:0] a, input logic [15:0] wd,
                         output int lat, output logic [15:0] rdata,
                         output int wren_cycles, output logic [11:0] wr_addr,
                         output logic [11:0] done_addr);
    bit done;
    drive(inst, port, rd, wr, a, wd);
    lat = -1; rdata = '0; wren_cycles = 0; wr_addr = '0; done_addr = '0;
    for (int e = 1; e <= 20; e++) begin
      @(negedge clk);
      if (inst == 1) begin
        if (b_mem_wren) begin wren_cycles++; wr_addr = b_mem_addr; end
        done = !b_dwait; rdata = b_drdata; done_addr = b_mem_addr;
      end else begin
        if (mem_wren) begin wren_cycles++; wr_addr = mem_addr; end
        done = port ? !d_wait : !p_wait;
        rdata = port ? d_rdata : p_rdata;
        done_addr = mem_addr;
      end
      @(posedge clk); #1;
      if (done) begin lat = e - 1; break; end
    end
    drive(inst, port, 1'b0, 1'b0, a, wd);
  endtask

  task automatic reset_a();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  typedef struct {
    bit          port;
    bit          rd;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wd;
    int          exp_lat;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs [8];

  int           lat, wc, pd, dd, ncomp;
  logic [15:0]  rd;
  logic [11:0]  wa, da;
  bit           preq, dreq, pc, dc;

  // Reference arbiter state: which port owns the memory and when it finishes
  bit           m_busy, m_grant, m_last, m_wr;
  int           m_done;
  logic [11:0]  m_addr;
  logic [15:0]  m_wd;

  initial begin
    rst_n = 1'b0; rst_b_n = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 4096; i++) ref_valid[i] = 1'b0;

    vecs[0] = '{1'b0, 1'b0, 1'b1, 16'h0005, 16'hBEEF, 2, 16'h0000};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000, 3, 16'hBEEF};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 16'hF00A, 16'h1234, 2, 16'h0000};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 16'h000A, 16'h0000, 3, 16'h1234};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 16'h0FFF, 16'hA5A5, 2, 16'h0000};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 16'h1FFF, 16'h0000, 3, 16'hA5A5};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0001, 2, 16'h0000};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 3, 16'h0001};

    // Reset state, and Waitreq follows a request even while reset is held
    repeat (2) @(negedge clk);
    chk("rst_wren", mem_wren, 1'b0);
    chk("rst_p_wait", p_wait, 1'b0);
    chk("rst_d_wait", d_wait, 1'b0);
    chk("rst_maddr", mem_addr, 12'h0);
    chk("rst_mwdata", mem_wdata, 16'h0);
    chk("rst_rdata", p_rdata, 16'h0);
    p_read = 1'b1; #1;
    chk("rst_p_wait_req", p_wait, 1'b1);
    p_read = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1; rst_b_n = 1'b1;

    foreach (vecs[i]) begin
      do_xfer(0, vecs[i].port, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, lat, rd, wc, wa, da);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      if (vecs[i].wr) begin
        chk($sformatf("vec%0d_wren_cycles", i), wc, 1);
        chk($sformatf("vec%0d_waddr", i), wa, vecs[i].addr[11:0]);
        ref_mem[vecs[i].addr[11:0]] = vecs[i].wd;
        ref_valid[vecs[i].addr[11:0]] = 1'b1;
      end else begin
        chk($sformatf("vec%0d_wren_cycles", i), wc, 0);
        chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      end
    end

    // Simultaneous reads from reset: P first, D after one IDLE bubble
    reset_a();
    drive(0, 1'b0, 1'b1, 1'b0, 16'h0005, 16'h0);
    drive(0, 1'b1, 1'b1, 1'b0, 16'h000A, 16'h0);
    pd = -1; dd = -1;
    for (int e = 1; e <= 16; e++) begin
      @(negedge clk);
      if (pd < 0 && p_read && !p_wait) begin pd = e - 1; chk("both_p_rdata", p_rdata, 16'hBEEF); end
      if (dd < 0 && d_read && !d_wait) begin dd = e - 1; chk("both_d_rdata", d_rdata, 16'h1234); end
      @(posedge clk); #1;
      if (pd >= 0) p_read = 1'b0;
      if (dd >= 0) d_read = 1'b0;
    end
    chk("both_p_edge", pd, 3);
    chk("both_d_edge", dd, 7);

    // Continuous writes from both ports alternate P,D,P,D with one bubble each
    reset_a();
    drive(0, 1'b0, 1'b0, 1'b1, 16'h0100, 16'h1000);
    drive(0, 1'b1, 1'b0, 1'b1, 16'h0200, 16'h2000);
    ncomp = 0;
    for (int e = 1; e <= 40 && ncomp < 8; e++) begin
      @(negedge clk);
      pc = p_write && !p_wait;
      dc = d_write && !d_wait;
      if (pc) begin
        chk("alt_edge", e - 1, 2 + 3 * ncomp);
        chk("alt_port_p", 0, ncomp % 2);
        ref_mem[p_addr[11:0]] = p_wdata; ref_valid[p_addr[11:0]] = 1'b1;
        ncomp++;
      end
      if (dc) begin
        chk("alt_edge", e - 1, 2 + 3 * ncomp);
        chk("alt_port_d", 1, ncomp % 2);
        ref_mem[d_addr[11:0]] = d_wdata; ref_valid[d_addr[11:0]] = 1'b1;
        ncomp++;
      end
      @(posedge clk); #1;
      if (pc) drive(0, 1'b0, 1'b0, 1'b1, p_addr + 16'h1, p_wdata + 16'h1);
      if (dc) drive(0, 1'b1, 1'b0, 1'b1, d_addr + 16'h1, d_wdata + 16'h1);
    end
    chk("alt_count", ncomp, 8);
    drive(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);

    // Randomized traffic against an event-level reference of the arbiter
    reset_a();
    m_busy = 1'b0; m_last = 1'b1; m_grant = 1'b0; m_done = 0; m_wr = 1'b0;
    m_addr = '0; m_wd = '0;
    for (int n = 1; n <= 1500; n++) begin
      @(negedge clk);
      preq = p_read | p_write;
      dreq = d_read | d_write;
      if (!m_busy && (preq || dreq)) begin
        m_grant = (preq && dreq) ? ~m_last : dreq;
        m_wr    = m_grant ? d_write : p_write;
        m_addr  = m_grant ? d_addr[11:0] : p_addr[11:0];
        m_wd    = m_grant ? d_wdata : p_wdata;
        m_busy  = 1'b1;
        m_done  = n + (m_wr ? 2 : 3);
      end
      chk("rand_p_wait", p_wait, preq && !(m_busy && !m_grant && n == m_done));
      chk("rand_d_wait", d_wait, dreq && !(m_busy && m_grant && n == m_done));
      if (m_busy && n == m_done && !m_wr && ref_valid[m_addr])
        chk("rand_rdata", m_grant ? d_rdata : p_rdata, ref_mem[m_addr]);
      @(posedge clk); #1;
      if (m_busy && n == m_done) begin
        if (m_wr) begin ref_mem[m_addr] = m_wd; ref_valid[m_addr] = 1'b1; end
        m_busy = 1'b0;
        m_last = m_grant;
        drive(0, m_grant, 1'b0, 1'b0, 16'h0, 16'h0);
      end
      for (int pt = 0; pt < 2; pt++) begin
        if (!(pt == 0 ? (p_read | p_write) : (d_read | d_write)) && $urandom_range(0, 2) != 0) begin
          bit wr;
          wr = 1'($urandom_range(0, 1));
          drive(0, 1'(pt), wr ? ($urandom_range(0, 3) == 0) : 1'b1, wr,
                {4'($urandom), 8'h00, 4'($urandom_range(0, 7))}, 16'($urandom));
        end
      end
    end
    drive(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);

    // MEM_LAT=3 instance: high address bits dropped, read takes 5 edges
    do_xfer(1, 1'b1, 1'b0, 1'b1, 16'h000A, 16'h5A5A, lat, rd, wc, wa, da);
    chk("l3_wr_lat", lat, 2);
    do_xfer(1, 1'b1, 1'b1, 1'b0, 16'hF00A, 16'h0, lat, rd, wc, wa, da);
    chk("l3_rd_lat", lat, 5);
    chk("l3_rd_data", rd, 16'h5A5A);
    chk("l3_rd_maddr", da, 12'h00A);

    // Reset during a write ACCESS drops MemWren at once
    drive(1, 1'b1, 1'b0, 1'b1, 16'h0033, 16'h7777);
    @(posedge clk); #2;
    chk("l3_access_wren", b_mem_wren, 1'b1);
    rst_b_n = 1'b0; #1;
    chk("l3_rst_wren", b_mem_wren, 1'b0);
    drive(1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    @(posedge clk); #2 rst_b_n = 1'b1;

    // Reset during RDWAIT: no ACK, then the held request is re-run in full
    drive(1, 1'b1, 1'b1, 1'b0, 16'h000A, 16'h0);
    repeat (3) @(posedge clk);
    #2 rst_b_n = 1'b0; #1;
    chk("l3_rdwait_rst_wren", b_mem_wren, 1'b0);
    chk("l3_rdwait_rst_wait", b_dwait, 1'b1);
    for (int e = 0; e < 3; e++) begin
      @(negedge clk);
      chk("l3_no_ack_in_reset", b_dwait, 1'b1);
    end
    @(posedge clk); #2 rst_b_n = 1'b1;
    do_xfer(1, 1'b1, 1'b1, 1'b0, 16'h000A, 16'h0, lat, rd, wc, wa, da);
    chk("l3_rearb_lat", lat, 5);
    chk("l3_rearb_data", rd, 16'h5A5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
